// File: rtl/chronos_pkg.sv
// Shared Chronos widths used by the commit queue and its helper caches.
package chronos;
    localparam int OBJECT_WIDTH          = 32;
    localparam int TS_WIDTH              = 32;
    localparam int TB_WIDTH              = 32;
    localparam int LOG_LAST_DEQ_VT_CACHE = 9;
endpackage

// File: rtl/last_deq_vt_cache_ram.sv
// Storage for the last-dequeue VT cache: one write port, one read port, registered read.
module simple_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // A read colliding with a write returns the old contents; the parent forwards.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/last_deq_vt_cache.sv
// Direct-mapped cache of the last dequeued virtual time per object, used to let
// a candidate task bypass the commit queue when it is strictly later.
module last_deq_vt_cache
    import chronos::*;
#(
    parameter int LOG_DEPTH = LOG_LAST_DEQ_VT_CACHE
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,

    input  logic                    lookup_valid,
    input  logic [OBJECT_WIDTH-1:0] lookup_object,
    input  logic [TS_WIDTH-1:0]     lookup_ts,
    input  logic [TB_WIDTH-1:0]     lookup_tb,

    output logic                    result_valid,
    output logic                    result_bypass,

    input  logic                    upd_valid,
    input  logic [OBJECT_WIDTH-1:0] upd_object,
    input  logic [TS_WIDTH-1:0]     upd_ts,
    input  logic [TB_WIDTH-1:0]     upd_tb,

    input  logic                    flush
);

    localparam int TAG_WIDTH = OBJECT_WIDTH - LOG_DEPTH;
    localparam int VT_WIDTH  = TS_WIDTH + TB_WIDTH;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [TS_WIDTH-1:0]  ts;
        logic [TB_WIDTH-1:0]  tb;
    } entry_t;

    typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

    state_t               state, state_next;
    logic [LOG_DEPTH-1:0] clear_idx, clear_idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            clear_idx <= '0;
        end else begin
            state     <= state_next;
            clear_idx <= clear_idx_next;
        end
    end

    always_comb begin
        state_next     = state;
        clear_idx_next = clear_idx;
        if (flush) begin
            state_next     = FLUSH;
            clear_idx_next = '0;
        end else if (state != RUN) begin
            clear_idx_next = clear_idx + 1'b1;
            if (&clear_idx) begin
                state_next = RUN;
            end
        end
    end

    assign ready = (state == RUN);

    logic                 lookup_accept, upd_accept;
    logic [LOG_DEPTH-1:0] lookup_idx, upd_idx;
    entry_t               upd_entry;

    assign lookup_accept = lookup_valid && ready;
    assign upd_accept    = upd_valid && ready && !flush;
    assign lookup_idx    = lookup_object[LOG_DEPTH-1:0];
    assign upd_idx       = upd_object[LOG_DEPTH-1:0];
    assign upd_entry     = '{valid: 1'b1, tag: upd_object[OBJECT_WIDTH-1:LOG_DEPTH],
                             ts: upd_ts, tb: upd_tb};

    // While not ready the write port belongs to the clear sweep.
    logic                 ram_wr_en;
    logic [LOG_DEPTH-1:0] ram_wr_addr;
    entry_t               ram_wr_data, ram_rd_data;

    assign ram_wr_en   = !ready || upd_accept;
    assign ram_wr_addr = ready ? upd_idx : clear_idx;
    assign ram_wr_data = ready ? upd_entry : '0;

    simple_dual_port_ram #(
        .DATA_WIDTH ($bits(entry_t)),
        .ADDR_WIDTH (LOG_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (lookup_idx),
        .rd_data (ram_rd_data)
    );

    logic                 prev_upd_valid;
    logic [LOG_DEPTH-1:0] prev_upd_idx;
    entry_t               prev_upd_entry;
    logic                 fwd_hit;
    entry_t               fwd_entry;

    // Same-cycle update wins over the previous cycle's update, which wins over the RAM.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_entry = upd_entry;
        if (upd_accept && (upd_idx == lookup_idx)) begin
            fwd_hit = 1'b1;
        end else if (prev_upd_valid && (prev_upd_idx == lookup_idx)) begin
            fwd_hit   = 1'b1;
            fwd_entry = prev_upd_entry;
        end
    end

    logic                 s1_valid, s1_kill, s1_fwd;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic [VT_WIDTH-1:0]  s1_vt;
    entry_t               s1_fwd_entry, s1_stored;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_upd_valid <= 1'b0;
            s1_valid       <= 1'b0;
            s1_kill        <= 1'b0;
        end else begin
            prev_upd_valid <= upd_accept;
            s1_valid       <= lookup_accept;
            s1_kill        <= flush;
        end
    end

    always_ff @(posedge clk) begin
        prev_upd_idx   <= upd_idx;
        prev_upd_entry <= upd_entry;
        s1_fwd         <= fwd_hit;
        s1_fwd_entry   <= fwd_entry;
        s1_tag         <= lookup_object[OBJECT_WIDTH-1:LOG_DEPTH];
        s1_vt          <= {lookup_ts, lookup_tb};
    end

    assign s1_stored     = s1_fwd ? s1_fwd_entry : ram_rd_data;
    assign result_valid  = s1_valid;
    assign result_bypass = s1_valid && !s1_kill && s1_stored.valid &&
                           (s1_stored.tag == s1_tag) &&
                           (s1_vt > {s1_stored.ts, s1_stored.tb});

endmodule

// File: tb/tb_last_deq_vt_cache.sv
// Directed bench for last_deq_vt_cache: scoreboard of expected lookup results plus sweep timing checks.
module tb_last_deq_vt_cache;
    import chronos::*;

    localparam int DEPTH = 2 ** LOG_LAST_DEQ_VT_CACHE;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    ready;
    logic                    lookup_valid = 1'b0;
    logic [OBJECT_WIDTH-1:0] lookup_object = '0;
    logic [TS_WIDTH-1:0]     lookup_ts = '0;
    logic [TB_WIDTH-1:0]     lookup_tb = '0;
    logic                    result_valid;
    logic                    result_bypass;
    logic                    upd_valid = 1'b0;
    logic [OBJECT_WIDTH-1:0] upd_object = '0;
    logic [TS_WIDTH-1:0]     upd_ts = '0;
    logic [TB_WIDTH-1:0]     upd_tb = '0;
    logic                    flush = 1'b0;

    last_deq_vt_cache dut (
        .clk           (clk),
        .rst           (rst),
        .ready         (ready),
        .lookup_valid  (lookup_valid),
        .lookup_object (lookup_object),
        .lookup_ts     (lookup_ts),
        .lookup_tb     (lookup_tb),
        .result_valid  (result_valid),
        .result_bypass (result_bypass),
        .upd_valid     (upd_valid),
        .upd_object    (upd_object),
        .upd_ts        (upd_ts),
        .upd_tb        (upd_tb),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    due;
        bit    bypass;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cycle = cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Every cycle result_valid must match the scoreboard; a due entry also checks bypass.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_v;
            exp_v = (sb.size() > 0) && (sb[0].due == cycle);
            checkOutput("result_valid", {63'd0, result_valid}, {63'd0, exp_v});
            if (exp_v) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput(e.tag, {63'd0, result_bypass}, {63'd0, e.bypass});
            end
        end
    end

    task automatic applyStimulus(input string tag,
                                 input bit lv, input logic [31:0] lobj, input logic [31:0] lts, input logic [31:0] ltb,
                                 input bit uv, input logic [31:0] uobj, input logic [31:0] uts, input logic [31:0] utb,
                                 input bit fl, input bit exp_res, input bit exp_byp);
        lookup_valid  = lv;
        lookup_object = lobj;
        lookup_ts     = lts;
        lookup_tb     = ltb;
        upd_valid     = uv;
        upd_object    = uobj;
        upd_ts        = uts;
        upd_tb        = utb;
        flush         = fl;
        if (exp_res) sb.push_back('{due: cycle + 1, bypass: exp_byp, tag: tag});
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] obj, input logic [31:0] ts,
                          input logic [31:0] tb, input bit exp_byp);
        applyStimulus(tag, 1'b1, obj, ts, tb, 1'b0, '0, '0, '0, 1'b0, 1'b1, exp_byp);
    endtask

    task automatic update(input logic [31:0] obj, input logic [31:0] ts, input logic [31:0] tb);
        applyStimulus("upd", 1'b0, '0, '0, '0, 1'b1, obj, ts, tb, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus("idle", 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called 1 time unit after the edge that started a sweep, minus 'elapsed' edges already spent.
    task automatic waitReady(input string tag, input int elapsed);
        checkOutput({tag, "_ready_low_start"}, {63'd0, ready}, 64'd0);
        repeat (DEPTH - elapsed - 1) begin
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_ready_low_end"}, {63'd0, ready}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_ready_high"}, {63'd0, ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        checkOutput("rst_result_valid", {63'd0, result_valid}, 64'd0);
        checkOutput("rst_result_bypass", {63'd0, result_bypass}, 64'd0);
        waitReady("init", 0);
        lookup("empty_lookup", 32'h1234, 32'd500, 32'd0, 1'b0);

        update(32'h1234, 32'd10, 32'd5);
        lookup("tb_greater", 32'h1234, 32'd10, 32'd6, 1'b1);
        lookup("vt_equal", 32'h1234, 32'd10, 32'd5, 1'b0);
        lookup("ts_less", 32'h1234, 32'd9, 32'd99, 1'b0);
        idle(3);
        lookup("ram_read_hit", 32'h1234, 32'd11, 32'd0, 1'b1);

        update(32'h0234, 32'd3, 32'd0);
        lookup("tag_mismatch", 32'h1234, 32'd100, 32'd0, 1'b0);
        lookup("tag_match_new", 32'h0234, 32'd100, 32'd0, 1'b1);

        applyStimulus("same_cycle_fwd", 1'b1, 32'h55, 32'd21, 32'd0, 1'b1, 32'h55, 32'd20, 32'd0, 1'b0, 1'b1, 1'b1);
        update(32'h55, 32'd30, 32'd0);
        lookup("prev_cycle_fwd", 32'h55, 32'd25, 32'd0, 1'b0);
        applyStimulus("same_cycle_stale", 1'b1, 32'h55, 32'd35, 32'd0, 1'b1, 32'h55, 32'd40, 32'd0, 1'b0, 1'b1, 1'b0);

        update(32'h7, 32'd1, 32'd0);
        applyStimulus("flush1", 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus("lookup_not_ready", 1'b1, 32'h7, 32'd50, 32'd0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        waitReady("flush1", 1);
        lookup("after_flush", 32'h7, 32'd50, 32'd0, 1'b0);

        update(32'h9, 32'd1, 32'd0);
        idle(1);
        applyStimulus("flush_kills_lookup", 1'b1, 32'h9, 32'd5, 32'd0, 1'b1, 32'h9, 32'd4, 32'd0, 1'b1, 1'b1, 1'b0);
        idle(99);
        applyStimulus("flush2", 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        waitReady("flush2", 0);
        lookup("after_flush2", 32'h9, 32'd5, 32'd0, 1'b0);

        update(32'h21, 32'd2, 32'd0);
        idle(2);
        lookup("before_rst", 32'h21, 32'd3, 32'd0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitReady("rerst", 0);
        lookup("after_rst", 32'h21, 32'd3, 32'd0, 1'b0);

        idle(2);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
